// File: rtl/cargador_instrucciones.sv
// cargador_instrucciones: loads a program into instruction memory from a byte stream.
// Bytes arrive over a valid/ready handshake and are packed big-endian into 32-bit
// words, which are written to byte addresses 0, 4, 8, ... The CPU is held disabled
// while a load is in progress.
// Optional feature: define CARGADOR_CHECKSUM_EN to add a trailing checksum byte
// (8-bit wrap-around sum of all data bytes) that is compared into err_chk.
module cargador_instrucciones #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_palabras,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_wen,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_dato,
    output logic              ocupado,
    output logic              listo,
    output logic              cpu_en,
    output logic              err_chk
);

    localparam int unsigned NW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH = NW'(1) << ADDR_W;

`ifdef CARGADOR_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} estado_t;
`else
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} estado_t;
`endif

    estado_t           estado;
    logic [ADDR_W:0]   n_lat;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        nbyte;
    logic [23:0]       palabra;
`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0]        suma;
`endif

    logic              acepta_c;
    logic              ultima_c;
    logic [ADDR_W:0]   n_sol_c;

    // Handshake, last-word detection and word-count clamp to memory depth
    assign acepta_c = byte_valid && byte_ready;
    assign ultima_c = (NW'(idx) + NW'(1)) == n_lat;
    assign n_sol_c  = (num_palabras > DEPTH) ? DEPTH : num_palabras;

`ifndef CARGADOR_CHECKSUM_EN
    assign err_chk = 1'b0;
`endif

    // Load FSM with registered outputs; mem_wen is a single-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= IDLE;
            n_lat      <= '0;
            idx        <= '0;
            nbyte      <= '0;
            palabra    <= '0;
            byte_ready <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_dato   <= '0;
            ocupado    <= 1'b0;
            listo      <= 1'b0;
            cpu_en     <= 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
            suma       <= '0;
            err_chk    <= 1'b0;
`endif
        end else begin
            mem_wen <= 1'b0;
            case (estado)
                IDLE, DONE: begin
                    if (start) begin
                        n_lat  <= n_sol_c;
                        idx    <= '0;
                        nbyte  <= '0;
                        listo  <= 1'b0;
                        cpu_en <= 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
                        suma    <= '0;
                        err_chk <= 1'b0;
`endif
                        if (n_sol_c == '0) begin
                            estado <= DONE;
                            listo  <= 1'b1;
                            cpu_en <= 1'b1;
                        end else begin
                            estado     <= RECV;
                            byte_ready <= 1'b1;
                            ocupado    <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (acepta_c) begin
                        palabra <= {palabra[15:0], byte_in};
                        nbyte   <= nbyte + 2'd1;
`ifdef CARGADOR_CHECKSUM_EN
                        suma    <= suma + byte_in;
`endif
                        if (nbyte == 2'd3) begin
                            estado     <= WRITE;
                            byte_ready <= 1'b0;
                            mem_wen    <= 1'b1;
                            mem_addr   <= 32'({idx, 2'b00});
                            mem_dato   <= {palabra, byte_in};
                        end
                    end
                end
                WRITE: begin
                    idx <= idx + ADDR_W'(1);
                    if (ultima_c) begin
`ifdef CARGADOR_CHECKSUM_EN
                        estado     <= CHK;
                        byte_ready <= 1'b1;
`else
                        estado  <= DONE;
                        ocupado <= 1'b0;
                        listo   <= 1'b1;
                        cpu_en  <= 1'b1;
`endif
                    end else begin
                        estado     <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef CARGADOR_CHECKSUM_EN
                CHK: begin
                    if (acepta_c) begin
                        err_chk    <= (byte_in != suma);
                        estado     <= DONE;
                        byte_ready <= 1'b0;
                        ocupado    <= 1'b0;
                        listo      <= 1'b1;
                        cpu_en     <= 1'b1;
                    end
                end
`endif
                default: estado <= IDLE;
            endcase
        end
    end

endmodule
